// File: rtl/pipe_regfile_sb.sv
// pipe_regfile_sb: multi-read-port register file with an integrated
// busy-bit scoreboard. Tracks registers that have an issued producer not yet
// written back, reports per-port busy flags, and keeps a live count of busy
// registers.
// Optional feature macro: RF_BYPASS_EN -- when defined, a read port addressing
// the register being written this cycle returns wdata combinationally.
module pipe_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     wen,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [ADDR_W:0]   r_busy_cnt;

  logic w_wr_ok;
  logic w_iss_ok;
  logic w_cnt_inc;
  logic w_cnt_dec;

  // Register 0 is hardwired when ZERO_REG is set, so writes and issues to it
  // are dropped before they can touch state.
  assign w_wr_ok  = wen    && !((ZERO_REG != 0) && (waddr    == '0));
  assign w_iss_ok = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

  // Counter deltas mirror the busy-bit transitions exactly. A same-address
  // write+issue never decrements, since the issue keeps (or makes) it busy.
  assign w_cnt_inc = w_iss_ok && !r_busy[iss_addr];
  assign w_cnt_dec = w_wr_ok && r_busy[waddr] &&
                     !(w_iss_ok && (iss_addr == waddr));

  // Architectural register storage, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Busy bits: writeback clears, issue sets; issue is applied last so a newer
  // producer wins on a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      if (w_wr_ok) begin
        r_busy[waddr] <= 1'b0;
      end
      if (w_iss_ok) begin
        r_busy[iss_addr] <= 1'b1;
      end
    end
  end

  // Population count of busy bits, tracked incrementally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy_cnt <= '0;
    end else begin
      r_busy_cnt <= r_busy_cnt + {{ADDR_W{1'b0}}, w_cnt_inc}
                                - {{ADDR_W{1'b0}}, w_cnt_dec};
    end
  end

  assign busy_cnt = r_busy_cnt;

  // Independent combinational read ports; aliasing between ports is allowed.
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_zero;
    logic              w_byp;
    logic [DATA_W-1:0] w_rd;
    logic              w_rb;

    assign w_ra   = raddr[g*ADDR_W +: ADDR_W];
    assign w_zero = (ZERO_REG != 0) && (w_ra == '0);
`ifdef RF_BYPASS_EN
    assign w_byp  = w_wr_ok && (w_ra == waddr);
`else
    assign w_byp  = 1'b0;
`endif

    // Bypassed reads see the writeback as completed; only a same-cycle issue
    // to the same register keeps the port busy.
    assign w_rd = w_zero ? '0 :
                  w_byp  ? wdata :
                           r_mem[w_ra];
    assign w_rb = w_zero ? 1'b0 :
                  w_byp  ? (w_iss_ok && (iss_addr == w_ra)) :
                           r_busy[w_ra];

    assign rdata[g*DATA_W +: DATA_W] = w_rd;
    assign rbusy[g]                  = w_rb;
  end

endmodule

// File: tb/tb_pipe_regfile_sb.sv
// Directed self-checking bench for pipe_regfile_sb (default parameters).
module tb_pipe_regfile_sb;

  logic        clk;
  logic        rst;
  logic [4:0]  ra0, ra1;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic [5:0]  busy_cnt;
  logic [31:0] rd0, rd1;

  int checks = 0;
  int errors = 0;

  assign raddr = {ra1, ra0};
  assign rd0   = rdata[31:0];
  assign rd1   = rdata[63:32];

  pipe_regfile_sb dut (
    .clk      (clk),
    .rst      (rst),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_cnt (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    wen    = 1'b0;
    iss_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0;
    iss_en = 1'b0; iss_addr = '0; ra0 = 5'd5; ra1 = 5'd9;
    #2;
    checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    checks++; if (rbusy !== 2'b00) begin errors++; $display("FAIL reset_rbusy: got %b expected 00", rbusy); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", busy_cnt); end
    rst = 1'b0;
    // write r5 on the first edge after reset release
    wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    step();
    checks++; if (rd0 !== 32'hDEADBEEF) begin errors++; $display("FAIL write_r5: got %h expected deadbeef", rd0); end
    ra1 = 5'd5;
    #1;
    checks++; if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL alias_r5: got %h expected deadbeef", rd1); end
  endtask

  task automatic test_zero_reg();
    wen = 1'b1; waddr = 5'd0; wdata = 32'h1234;
    iss_en = 1'b1; iss_addr = 5'd0; ra0 = 5'd0;
    step();
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL zero_rdata: got %h expected 0", rd0); end
    checks++; if (rbusy[0] !== 1'b0) begin errors++; $display("FAIL zero_rbusy: got %b expected 0", rbusy[0]); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL zero_cnt: got %0d expected 0", busy_cnt); end
  endtask

  task automatic test_scoreboard();
    iss_en = 1'b1; iss_addr = 5'd3; ra0 = 5'd3;
    step();
    checks++; if (rbusy[0] !== 1'b1) begin errors++; $display("FAIL iss_r3_busy: got %b expected 1", rbusy[0]); end
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL iss_r3_cnt: got %0d expected 1", busy_cnt); end
    iss_en = 1'b1; iss_addr = 5'd7; ra1 = 5'd7;
    step();
    checks++; if (busy_cnt !== 6'd2) begin errors++; $display("FAIL iss_r7_cnt: got %0d expected 2", busy_cnt); end
    checks++; if (rbusy !== 2'b11) begin errors++; $display("FAIL iss_r7_busy: got %b expected 11", rbusy); end
    wen = 1'b1; waddr = 5'd3; wdata = 32'h55;
    step();
    checks++; if (rbusy[0] !== 1'b0) begin errors++; $display("FAIL wb_r3_busy: got %b expected 0", rbusy[0]); end
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL wb_r3_cnt: got %0d expected 1", busy_cnt); end
    checks++; if (rd0 !== 32'h55) begin errors++; $display("FAIL wb_r3_data: got %h expected 55", rd0); end
    // issue to an already-busy register: no change
    iss_en = 1'b1; iss_addr = 5'd7;
    step();
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL reiss_r7_cnt: got %0d expected 1", busy_cnt); end
    // write to a non-busy register: no underflow
    wen = 1'b1; waddr = 5'd5; wdata = 32'h77; ra0 = 5'd5;
    step();
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL wb_idle_cnt: got %0d expected 1", busy_cnt); end
    checks++; if (rd0 !== 32'h77) begin errors++; $display("FAIL wb_idle_data: got %h expected 77", rd0); end
  endtask

  task automatic test_simultaneous();
    // busy now: r7 (cnt 1)
    wen = 1'b1; waddr = 5'd9; wdata = 32'hAA;
    iss_en = 1'b1; iss_addr = 5'd9; ra0 = 5'd9;
    step();
    checks++; if (rd0 !== 32'hAA) begin errors++; $display("FAIL same_r9_data: got %h expected aa", rd0); end
    checks++; if (rbusy[0] !== 1'b1) begin errors++; $display("FAIL same_r9_busy: got %b expected 1", rbusy[0]); end
    checks++; if (busy_cnt !== 6'd2) begin errors++; $display("FAIL same_r9_cnt: got %0d expected 2", busy_cnt); end
    iss_en = 1'b1; iss_addr = 5'd3;
    step();
    checks++; if (busy_cnt !== 6'd3) begin errors++; $display("FAIL iss_r3b_cnt: got %0d expected 3", busy_cnt); end
    wen = 1'b1; waddr = 5'd3; wdata = 32'h66;
    iss_en = 1'b1; iss_addr = 5'd4; ra0 = 5'd3; ra1 = 5'd4;
    step();
    checks++; if (busy_cnt !== 6'd3) begin errors++; $display("FAIL diff_cnt: got %0d expected 3", busy_cnt); end
    checks++; if (rbusy !== 2'b10) begin errors++; $display("FAIL diff_busy: got %b expected 10", rbusy); end
    checks++; if (rd0 !== 32'h66) begin errors++; $display("FAIL diff_data: got %h expected 66", rd0); end
  endtask

  task automatic test_bypass();
    // busy now: r4, r7, r9 (cnt 3)
    wen = 1'b1; waddr = 5'd2; wdata = 32'h10;
    step();
    iss_en = 1'b1; iss_addr = 5'd2;
    step();
    checks++; if (busy_cnt !== 6'd4) begin errors++; $display("FAIL byp_setup_cnt: got %0d expected 4", busy_cnt); end
    wen = 1'b1; waddr = 5'd2; wdata = 32'h20; ra1 = 5'd2;
    #1;
`ifdef RF_BYPASS_EN
    checks++; if (rd1 !== 32'h20) begin errors++; $display("FAIL byp_same_data: got %h expected 20", rd1); end
    checks++; if (rbusy[1] !== 1'b0) begin errors++; $display("FAIL byp_same_busy: got %b expected 0", rbusy[1]); end
`else
    checks++; if (rd1 !== 32'h10) begin errors++; $display("FAIL nobyp_same_data: got %h expected 10", rd1); end
    checks++; if (rbusy[1] !== 1'b1) begin errors++; $display("FAIL nobyp_same_busy: got %b expected 1", rbusy[1]); end
`endif
    step();
    checks++; if (rd1 !== 32'h20) begin errors++; $display("FAIL byp_next_data: got %h expected 20", rd1); end
    checks++; if (rbusy[1] !== 1'b0) begin errors++; $display("FAIL byp_next_busy: got %b expected 0", rbusy[1]); end
    checks++; if (busy_cnt !== 6'd3) begin errors++; $display("FAIL byp_next_cnt: got %0d expected 3", busy_cnt); end
  endtask

  task automatic test_mid_reset();
    wen = 1'b1; waddr = 5'd4; wdata = 32'h99;
    iss_en = 1'b1; iss_addr = 5'd4; ra0 = 5'd4; ra1 = 5'd7;
    step();
    checks++; if (rd0 !== 32'h99 || rbusy[0] !== 1'b1) begin errors++; $display("FAIL pre_rst_r4: got %h/%b expected 99/1", rd0, rbusy[0]); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL mid_rst_rdata: got %h expected 0", rdata); end
    checks++; if (rbusy !== 2'b00) begin errors++; $display("FAIL mid_rst_rbusy: got %b expected 00", rbusy); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d expected 0", busy_cnt); end
    #1;
    rst = 1'b0;
    wen = 1'b1; waddr = 5'd6; wdata = 32'h42;
    iss_en = 1'b1; iss_addr = 5'd7; ra0 = 5'd6;
    step();
    checks++; if (rd0 !== 32'h42) begin errors++; $display("FAIL post_rst_data: got %h expected 42", rd0); end
    checks++; if (rbusy[1] !== 1'b1 || busy_cnt !== 6'd1) begin errors++; $display("FAIL post_rst_iss: got %b/%0d expected 1/1", rbusy[1], busy_cnt); end
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_scoreboard();
    test_simultaneous();
    test_bypass();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_regfile_sb.md
# pipe_regfile_sb

Parametrised multi-read-port register file with an integrated busy-bit scoreboard for the pipelined datapath. It replaces the fixed 32×32, two-read-port file in the decode stage. It holds architectural register state, tracks which registers have an outstanding producer (issued but not yet written back), and exports per-port busy flags to the hazard unit. An optional write-to-read bypass removes the writeback/decode same-cycle hazard.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes and issues
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- raddr  input  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rdata  output  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
- rbusy  output  NUM_RD  per-port busy flag for the addressed register
- wen  input  1  writeback strobe
- waddr  input  ADDR_W  writeback address
- wdata  input  DATA_W  writeback data
- iss_en  input  1  issue strobe; marks iss_addr as having a pending producer
- iss_addr  input  ADDR_W  destination register of the issued instruction
- busy_cnt  output  ADDR_W+1  number of registers currently busy

## Operation
- Storage: 2^ADDR_W × DATA_W registers plus 2^ADDR_W busy bits.
- Reset (rst=1, asynchronous): all registers cleared to 0, all busy bits cleared, busy_cnt=0. Hence rdata=0 and rbusy=0 on every port while in reset.
- Write: on a rising edge with wen=1, reg[waddr] <= wdata and busy[waddr] <= 0.
- Issue: on a rising edge with iss_en=1, busy[iss_addr] <= 1.
- Same edge, wen and iss_en to the same address: the data is written and busy ends at 1. Issue wins because a newer producer is pending.
- Same edge, different addresses: both updates take effect independently.
- Write to a register that is not busy: the data is still written. busy is unchanged at 0, and busy_cnt does not underflow.
- Issue to a register that is already busy: busy stays 1 and busy_cnt is unchanged. There is no nesting or count per register.
- ZERO_REG=1: write and issue to address 0 are ignored. rdata for address 0 is 0 and rbusy for address 0 is 0 regardless of inputs.
- busy_cnt equals the population count of the busy bits, maintained as a registered up/down counter:
  - +1 when a not-busy register becomes busy;
  - −1 when a busy register is cleared;
  - net 0 for an issue and a clear to different addresses on the same edge.
- Reads are combinational from the stored state; all NUM_RD ports are independent and may alias the same address.

## Timing
- Read latency: 0 cycles (combinational from raddr and state).
- Write and issue take effect at the rising edge. Without bypass, the new value and busy state are visible on reads in the following cycle.
- busy_cnt is registered and updates on the same edge as the busy bits.
- Reset asserted mid-operation clears state immediately, independent of clk. On the first rising edge after rst deasserts, wen and iss_en are honoured normally.

## Configuration
- RF_BYPASS_EN defined: a read port whose raddr equals waddr while wen=1 (address non-zero when ZERO_REG=1) returns wdata combinationally in the same cycle.
  - Its rbusy is forced to 0 for that cycle, unless iss_en=1 with iss_addr equal to the same address, in which case rbusy=1.
- RF_BYPASS_EN undefined: reads always return the stored value and stored busy bit. A same-cycle write is visible only from the next cycle.

## Test plan
- Reset and read-back:
  - pulse rst with no clock edge -> all rdata=0, rbusy=0, busy_cnt=0;
  - then write 0xDEADBEEF to r5 -> raddr port0=5 reads 0xDEADBEEF next cycle.
- Zero register: write 0x1234 to r0 and issue r0 -> rdata for r0 = 0, rbusy=0, busy_cnt=0.
- Scoreboard lifecycle:
  - issue r3 -> rbusy=1 and busy_cnt=1 next cycle;
  - issue r7 -> busy_cnt=2;
  - write r3 = 0x55 -> r3 rbusy=0, busy_cnt=1, rdata=0x55.
- Simultaneous events:
  - same edge wen r9 = 0xAA and iss_en r9 -> r9 reads 0xAA with rbusy=1, busy_cnt +1;
  - same edge write r3 (busy) and issue r4 -> busy_cnt unchanged.
- Bypass, with RF_BYPASS_EN:
  - r2 holds 0x10 and is busy; in one cycle wen r2 = 0x20 with raddr port1=2 -> rdata port1=0x20 and rbusy=0 that cycle.
  - Without the macro, the same stimulus gives 0x10 and rbusy=1, then 0x20 and rbusy=0 the next cycle.
- Reset mid-operation: with r4=0x99 and r4 busy, assert rst between clock edges -> rdata=0, rbusy=0 and busy_cnt=0 immediately.
